rec_rom_fetcher: RTL
====================

Name: rec_rom_fetcher

Overview:
Initiator side of the recovery-code ROM read interface. On a recovery trigger it walks the recovery code ROM from ROM_BASE, issuing one-cycle-latency reads. It buffers the returned words in a small FIFO and hands them to the core-side debug/recovery injector over a valid/ready stream. It sits between the debug-mode recovery controller and recovery_code_rom.

Parameters:
ROM_BASE, 32'h0004_0080, byte address of the first recovery instruction.
CODE_WORDS, 16, number of 32-bit words to fetch (1..256).
FIFO_DEPTH, 2, output buffer entries (power of two, >=2).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse: begin a fetch sequence
abort_i  in  1  cancel the sequence; flush the FIFO
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse when the last word is accepted downstream
rom_req_o  out  1  ROM read request
rom_addr_o  out  32  ROM byte address
rom_rdata_i  in  32  ROM data, valid the cycle after rom_req_o was high
instr_valid_o  out  1  instr_o/instr_addr_o valid
instr_ready_i  in  1  consumer accepts the current word
instr_o  out  32  fetched word
instr_addr_o  out  32  address of instr_o

Behaviour:
- Reset values:
  - busy_o=0, done_o=0, rom_req_o=0, rom_addr_o=ROM_BASE, instr_valid_o=0, instr_o=0, instr_addr_o=0.
  - FSM=IDLE, FIFO empty, counters=0.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: start_i -> FETCH; issue counter=0, accept counter=0.
  - FETCH: rom_req_o is asserted in any cycle where the credit rule allows it (below).
    - rom_addr_o = ROM_BASE + 4*issue_cnt.
    - issue_cnt increments on each request.
    - After CODE_WORDS requests -> DRAIN.
  - DRAIN: no requests. When accept_cnt reaches CODE_WORDS -> IDLE, pulse done_o in that same cycle.
- Credit rule: request only when fifo_count + inflight + (1 if a pop occurs this cycle? no) < FIFO_DEPTH.
  - inflight is 1 if rom_req_o was high in the previous cycle.
  - Pops in the current cycle are not credited; the rule is conservative, which keeps the request path free of instr_ready_i.
- Response capture: a registered req_q marks the response. When req_q=1, push {rom_rdata_i, addr_q} into the FIFO the same cycle. A push is never refused (guaranteed by the credit rule).
- Output: instr_valid_o = FIFO non-empty; instr_o/instr_addr_o = FIFO head.
  - A pop occurs on instr_valid_o & instr_ready_i, and accept_cnt increments.
  - Push and pop in the same cycle are legal; the count is unchanged.
- Throughput: with FIFO_DEPTH>=2 and instr_ready_i held high, one word per cycle is sustained after 1 cycle of initial latency (start_i at cycle N, first rom_req_o at N+1, first instr_valid_o at N+2).
- busy_o = (state != IDLE).
- start_i while busy: ignored.
- abort_i (priority over start_i, any state):
  - Next cycle: state=IDLE, FIFO flushed, rom_req_o=0, no done_o.
  - Any response arriving the cycle after abort is discarded.
- Backpressure: with instr_ready_i held low, requests stop once FIFO_DEPTH words are buffered or in flight. There is no overflow and no data loss.
- Address arithmetic is 32-bit wraparound. issue_cnt/accept_cnt are $clog2(CODE_WORDS+1) bits wide.
- Asynchronous reset mid-sequence returns all state to the reset values immediately.

Optional Feature:
Macro REC_FETCH_CHECKSUM_EN.
- Defined:
  - Adds output checksum_o[31:0], the XOR of all words popped in the current sequence. It clears on start_i and is held after done_o.
  - Adds parameter EXP_CHECKSUM (default 0) and output checksum_ok_o, asserted with done_o and held until the next start_i when checksum_o == EXP_CHECKSUM.
- Undefined: the ports and logic are absent.

Decomposition:
- Package rec_fetch_pkg:
  - typedef fetch_state_e {IDLE, FETCH, DRAIN}.
  - typedef fifo_entry_t {logic [31:0] data; logic [31:0] addr}.
  - localparam WORD_BYTES=4.
- Sub-module rec_fetch_fifo: a synchronous FIFO of fifo_entry_t with push/pop/flush/count. All other logic lives in the top module.

Test Plan:
- Reset, then start_i with ready=1, ROM model (1-cycle latency, data=addr^32'hA5A5A5A5), CODE_WORDS=16 -> 16 consecutive words, addrs 0x40080..0x400BC, first valid at start+2, done_o at start+17, busy_o low next cycle.
- instr_ready_i toggled 1/0 each cycle -> all 16 words in order, no duplicates or drops; at most FIFO_DEPTH requests outstanding at any time.
- instr_ready_i held low 20 cycles after start -> exactly 2 rom_req_o pulses, then stall. Releasing ready completes the sequence.
- abort_i at the 5th accepted word -> next cycle instr_valid_o=0, busy_o=0, no further requests, no done_o. A new start_i re-fetches from 0x40080.
- start_i pulsed mid-sequence -> ignored; the sequence still ends after 16 words with a single done_o.
- With REC_FETCH_CHECKSUM_EN defined, EXP_CHECKSUM set to the model's XOR -> checksum_ok_o=1 at done_o. Corrupt one ROM word -> checksum_ok_o=0.

Source files
------------

// File: rtl/rec_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rec_fetch_pkg
// Shared types and constants for the recovery-code ROM fetcher:
//   fetch_state_e : sequencer states (IDLE, FETCH, DRAIN)
//   fifo_entry_t  : one buffered ROM word together with its byte address
//   WORD_BYTES    : byte stride between consecutive 32-bit ROM words
//   word_addr()   : byte address of the idx-th word above a base address
// -----------------------------------------------------------------------------
package rec_fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
    } fifo_entry_t;

    // 32-bit wraparound address of word idx counted from base
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx * 32'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/rec_fetch_fifo.sv
// -----------------------------------------------------------------------------
// rec_fetch_fifo
// Small synchronous FIFO of fifo_entry_t used as the fetcher's output buffer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : drop all contents (wins over push/pop)
//   push_i        : write push_data_i at the tail
//   push_data_i   : entry to write
//   pop_i         : discard the head entry (caller guarantees non-empty)
//   head_o        : current head entry (meaningful only when count_o != 0)
//   count_o       : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module rec_fetch_fifo
    import rec_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  fifo_entry_t                   push_data_i,
    input  logic                          pop_i,
    output fifo_entry_t                   head_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fifo_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // Storage, pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (flush_i) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_i) begin
                mem_r[wr_ptr_r] <= push_data_i;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_o  = mem_r[rd_ptr_r];
    assign count_o = count_r;

endmodule

// File: rtl/rec_rom_fetcher.sv
// -----------------------------------------------------------------------------
// rec_rom_fetcher
// Walks the recovery-code ROM from ROM_BASE on start_i, issuing one-cycle-
// latency reads, buffers the returned words and streams them to the recovery
// injector over a valid/ready handshake.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : begin a sequence (ignored while busy)
//   abort_i                : cancel the sequence and flush the buffer
//   busy_o, done_o         : sequence active / last word accepted pulse
//   rom_req_o, rom_addr_o  : ROM read request and byte address
//   rom_rdata_i            : ROM data, valid the cycle after a request
//   instr_valid_o/ready_i  : output stream handshake
//   instr_o, instr_addr_o  : fetched word and its byte address
// Optional build macro REC_FETCH_CHECKSUM_EN adds parameter EXP_CHECKSUM and
// outputs checksum_o (XOR of accepted words) and checksum_ok_o.
// -----------------------------------------------------------------------------
module rec_rom_fetcher
    import rec_fetch_pkg::*;
#(
    parameter logic [31:0] ROM_BASE     = 32'h0004_0080,
    parameter int unsigned CODE_WORDS   = 16,
`ifdef REC_FETCH_CHECKSUM_EN
    parameter logic [31:0] EXP_CHECKSUM = 32'h0000_0000,
`endif
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
`ifdef REC_FETCH_CHECKSUM_EN
    output logic [31:0] checksum_o,
    output logic        checksum_ok_o,
`endif
    input  logic        start_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o
);

    localparam int unsigned CNT_W  = $clog2(CODE_WORDS + 1);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CODE_WORDS - 1);

    fetch_state_e       state_r;
    fetch_state_e       state_s;
    logic [CNT_W-1:0]   issue_cnt_r;
    logic [CNT_W-1:0]   accept_cnt_r;
    logic               req_q_r;
    logic [31:0]        addr_q_r;

    logic               rom_req_s;
    logic               busy_s;
    logic               done_s;
    logic               start_ok_s;
    logic               credit_s;
    logic               pop_s;
    logic               head_valid_s;
    logic               fifo_empty_s;
    logic               fifo_push_s;
    logic               fifo_pop_s;
    logic [FCNT_W-1:0]  fifo_count_s;
    fifo_entry_t        fifo_head_s;
    fifo_entry_t        push_entry_s;
    fifo_entry_t        head_s;

    // A new sequence is only accepted from IDLE and never alongside abort
    assign start_ok_s = (state_r == IDLE) && start_i && !abort_i;

    // Credit counts buffered words plus the one in flight; pops this cycle are
    // deliberately not credited so the request path never sees instr_ready_i
    assign credit_s = (({1'b0, fifo_count_s} + {FCNT_W'(0), req_q_r}) < (FCNT_W + 1)'(FIFO_DEPTH));

    assign rom_addr_o   = word_addr(ROM_BASE, 32'(issue_cnt_r));
    assign push_entry_s = '{data: rom_rdata_i, addr: addr_q_r};

    // A response arriving into an empty buffer is presented immediately so a
    // two-entry buffer sustains one word per cycle
    assign fifo_empty_s = (fifo_count_s == FCNT_W'(0));
    assign head_valid_s = !fifo_empty_s || req_q_r;
    assign pop_s        = head_valid_s && instr_ready_i;
    assign fifo_push_s  = req_q_r && !(pop_s && fifo_empty_s);
    assign fifo_pop_s   = pop_s && !fifo_empty_s;

    // Sequencer state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sequencer next-state logic; abort returns to IDLE from any state
    always_comb begin
        state_s = state_r;
        if (abort_i) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FETCH: begin
                    if (rom_req_s && (issue_cnt_r == LAST_IDX)) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = FETCH;
                    end
                end
                DRAIN: begin
                    if (done_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // Sequencer outputs: request gating, busy and the completion pulse
    always_comb begin
        rom_req_s = 1'b0;
        busy_s    = 1'b0;
        case (state_r)
            IDLE: begin
                rom_req_s = 1'b0;
                busy_s    = 1'b0;
            end
            FETCH: begin
                rom_req_s = credit_s && !abort_i;
                busy_s    = 1'b1;
            end
            DRAIN: begin
                rom_req_s = 1'b0;
                busy_s    = 1'b1;
            end
            default: begin
                rom_req_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
        done_s = busy_s && !abort_i && pop_s && (accept_cnt_r == LAST_IDX);
    end

    // Issue and accept counters, cleared when a sequence starts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_cnt_r  <= CNT_W'(0);
            accept_cnt_r <= CNT_W'(0);
        end else if (start_ok_s) begin
            issue_cnt_r  <= CNT_W'(0);
            accept_cnt_r <= CNT_W'(0);
        end else begin
            if (rom_req_s) begin
                issue_cnt_r <= issue_cnt_r + CNT_W'(1);
            end
            if (pop_s && busy_s) begin
                accept_cnt_r <= accept_cnt_r + CNT_W'(1);
            end
        end
    end

    // Response tracking: req_q_r marks the cycle rom_rdata_i is valid; it is
    // never set by an abort cycle because rom_req_s is gated by abort_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q_r  <= 1'b0;
            addr_q_r <= 32'h0000_0000;
        end else begin
            req_q_r <= rom_req_s;
            if (rom_req_s) begin
                addr_q_r <= rom_addr_o;
            end else begin
                addr_q_r <= addr_q_r;
            end
        end
    end

    rec_fetch_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (abort_i),
        .push_i      (fifo_push_s),
        .push_data_i (push_entry_s),
        .pop_i       (fifo_pop_s),
        .head_o      (fifo_head_s),
        .count_o     (fifo_count_s)
    );

    // Output head selection: buffered head, else bypassed response, else zero
    always_comb begin
        head_s = '0;
        if (!fifo_empty_s) begin
            head_s = fifo_head_s;
        end else if (req_q_r) begin
            head_s = push_entry_s;
        end else begin
            head_s = '0;
        end
    end

    assign rom_req_o     = rom_req_s;
    assign busy_o        = busy_s;
    assign done_o        = done_s;
    assign instr_valid_o = head_valid_s;
    assign instr_o       = head_s.data;
    assign instr_addr_o  = head_s.addr;

`ifdef REC_FETCH_CHECKSUM_EN
    logic [31:0] checksum_r;
    logic        checksum_ok_r;
    logic [31:0] checksum_next_s;
    logic        checksum_match_s;

    assign checksum_next_s  = checksum_r ^ head_s.data;
    assign checksum_match_s = (checksum_next_s == EXP_CHECKSUM);

    // Running XOR of accepted words and the sticky match flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_r    <= 32'h0000_0000;
            checksum_ok_r <= 1'b0;
        end else if (start_ok_s) begin
            checksum_r    <= 32'h0000_0000;
            checksum_ok_r <= 1'b0;
        end else begin
            if (pop_s && busy_s) begin
                checksum_r <= checksum_next_s;
            end
            if (done_s) begin
                checksum_ok_r <= checksum_match_s;
            end
        end
    end

    assign checksum_o    = checksum_r;
    // The last word is folded in combinationally so the flag rises with done_o
    assign checksum_ok_o = checksum_ok_r || (done_s && checksum_match_s);
`endif

endmodule
